aes_enc_iter: RTL

Iterative AES encryption core, parametrised for 128/192/256-bit keys (FIPS-197). It expands a loaded key once into an internal round-key store, then encrypts 128-bit blocks at one round per clock behind valid/ready handshakes. It is the area-reduced, multi-key-size successor to the team's single-cycle AES-128 cipher, and sits between the block-mode controller (upstream) and the output packer (downstream).

---
 rtl/aes_enc_iter_if.sv | 23 ++
 rtl/aes_enc_iter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_iter_if.sv
// Handshake bundle for aes_enc_iter: key load, plaintext in, ciphertext out.
// master drives the request side (block-mode controller); slave is the core.
interface aes_enc_iter_if;
    logic         key_load;
    logic [255:0] key_in;
    logic         key_ready;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output key_load, key_in, in_valid, in_data, out_ready,
        input  key_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  key_load, key_in, in_valid, in_data, out_ready,
        output key_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/192/256 encryptor: expands the key one word per cycle into
// a round-key store, then runs one cipher round per cycle.
module aes_enc_iter #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    aes_enc_iter_if.slave bus
);

    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = 4 * (NR + 1);

    typedef enum logic [2:0] {StIdle, StKeyExp, StReady, StRound, StDone} state_e;

    state_e       state_q, state_d;
    logic [127:0] data_q, data_d;
    logic [3:0]   round_q, round_d;
    logic [5:0]   widx_q, widx_d;
    logic [2:0]   kmod_q, kmod_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  w_q [60];

    logic         key_wr, word_wr, start_load;
    logic [31:0]  prev_w, old_w, temp_w, word_new;
    logic [5:0]   rk_base;
    logic [127:0] rk_cur;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x14, x15, t, v;
        x2  = gf_mul(x, x);
        x3  = gf_mul(x2, x);
        t   = gf_mul(x3, x3);
        x12 = gf_mul(t, t);
        x14 = gf_mul(x12, x2);
        x15 = gf_mul(x12, x3);
        t   = gf_mul(x15, x15);
        t   = gf_mul(t, t);
        t   = gf_mul(t, t);
        t   = gf_mul(t, t);
        v   = gf_mul(t, x14);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input logic         last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int n = 0; n < 16; n++) b[n] = sbox(s[127-8*n -: 8]);
        // Byte n is s[n%4, n/4]; row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
        end
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c];
            a1 = t[4*c+1];
            a2 = t[4*c+2];
            a3 = t[4*c+3];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return o ^ rk;
    endfunction

    always_comb begin
        rk_base = (state_q == StRound) ? {round_q, 2'b00} : 6'd0;
        rk_cur  = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    end

    always_comb begin
        prev_w = w_q[widx_q - 6'd1];
        old_w  = w_q[widx_q - 6'(NK)];
        temp_w = prev_w;
        if (kmod_q == 3'd0) begin
            temp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && kmod_q == 3'd4) begin
            temp_w = sub_word(prev_w);
        end
        word_new = old_w ^ temp_w;
    end

    assign start_load = bus.key_load && (state_q == StIdle || state_q == StReady);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        round_d = round_q;
        widx_d  = widx_q;
        kmod_d  = kmod_q;
        rcon_d  = rcon_q;
        key_wr  = 1'b0;
        word_wr = 1'b0;
        if (start_load) begin
            key_wr  = 1'b1;
            widx_d  = 6'(NK);
            kmod_d  = 3'd0;
            rcon_d  = 8'h01;
            state_d = StKeyExp;
        end else begin
            case (state_q)
                StKeyExp: begin
                    word_wr = 1'b1;
                    widx_d  = widx_q + 6'd1;
                    kmod_d  = (kmod_q == 3'(NK - 1)) ? 3'd0 : kmod_q + 3'd1;
                    if (kmod_q == 3'd0) rcon_d = xtime(rcon_q);
                    if (widx_q == 6'(NW - 1)) state_d = StReady;
                end
                StReady: begin
                    if (bus.in_valid) begin
                        data_d  = bus.in_data ^ rk_cur;
                        round_d = 4'd1;
                        state_d = StRound;
                    end
                end
                StRound: begin
                    data_d  = enc_round(data_q, rk_cur, round_q == 4'(NR));
                    round_d = round_q + 4'd1;
                    if (round_q == 4'(NR)) state_d = StDone;
                end
                StDone: begin
                    if (bus.out_ready) state_d = StReady;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            round_q <= '0;
            widx_q  <= '0;
            kmod_q  <= '0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            round_q <= round_d;
            widx_q  <= widx_d;
            kmod_q  <= kmod_d;
            rcon_q  <= rcon_d;
        end
    end

    // Round-key store is not reset; it is only read after a full expansion.
    always_ff @(posedge clk) begin
        if (key_wr) begin
            for (int unsigned k = 0; k < NK; k++) w_q[k] <= bus.key_in[255-32*k -: 32];
        end
        if (word_wr) w_q[widx_q] <= word_new;
    end

    assign bus.key_ready = (state_q == StReady);
    assign bus.in_ready  = (state_q == StReady) && !bus.key_load;
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = (state_q == StDone) ? data_q : '0;

endmodule
